// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider with shadowed period/high-time config.
// Outputs are registered (one edge after the inputs that cause them); config changes take effect only at period boundaries.
module clk_div_prog #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 128,
    parameter int DEF_HIGH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH*CNT_W-1:0] div,
    input  logic [N_CH*CNT_W-1:0] high,
    input  logic [N_CH-1:0]       load,
    input  logic                  sync,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       pending
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_D  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_H  = CNT_W'(DEF_HIGH);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt, act_div, act_high, sh_div, sh_high;
        logic             run, pend, clk_q, tick_q;
        logic [CNT_W-1:0] cnt_nxt, ad_nxt, ah_nxt, sd_nxt, sh_nxt;
        logic [CNT_W-1:0] per_cur, per_nxt, hi_nxt, div_k, high_k;
        logic             run_nxt, pend_nxt, wrap;

        assign div_k  = div[k*CNT_W +: CNT_W];
        assign high_k = high[k*CNT_W +: CNT_W];

        always_comb begin
            cnt_nxt  = cnt;
            run_nxt  = run;
            pend_nxt = pend;
            ad_nxt   = act_div;
            ah_nxt   = act_high;
            sd_nxt   = sh_div;
            sh_nxt   = sh_high;
            per_cur  = (act_div < TWO) ? TWO : act_div;
            wrap     = run && (cnt >= per_cur - ONE);

            if (!en[k]) begin
                cnt_nxt  = '0;
                run_nxt  = 1'b0;
                pend_nxt = 1'b0;
                if (pend) begin
                    ad_nxt = sh_div;
                    ah_nxt = sh_high;
                end
            end else if (sync && load[k]) begin
                // Fresh config bypasses the shadow and starts at the sync edge.
                cnt_nxt  = '0;
                run_nxt  = 1'b1;
                ad_nxt   = div_k;
                ah_nxt   = high_k;
                pend_nxt = 1'b0;
            end else begin
                run_nxt = 1'b1;
                if (sync || wrap || !run) begin
                    cnt_nxt  = '0;
                    pend_nxt = 1'b0;
                    if (pend) begin
                        ad_nxt = sh_div;
                        ah_nxt = sh_high;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end

            // A load in a wrap cycle lands after the old shadow was consumed, so it stays pending.
            if (load[k]) begin
                sd_nxt = div_k;
                sh_nxt = high_k;
                if (!(en[k] && sync)) begin
                    pend_nxt = 1'b1;
                end
            end

            per_nxt = (ad_nxt < TWO) ? TWO : ad_nxt;
            hi_nxt  = (ah_nxt > per_nxt - ONE) ? (per_nxt - ONE) : ah_nxt;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                run      <= 1'b0;
                pend     <= 1'b0;
                act_div  <= DEF_D;
                act_high <= DEF_H;
                sh_div   <= DEF_D;
                sh_high  <= DEF_H;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                run      <= run_nxt;
                pend     <= pend_nxt;
                act_div  <= ad_nxt;
                act_high <= ah_nxt;
                sh_div   <= sd_nxt;
                sh_high  <= sh_nxt;
                clk_q    <= run_nxt && (cnt_nxt < hi_nxt);
                tick_q   <= run_nxt && (cnt_nxt == '0);
            end
        end

        assign clk_out[k] = clk_q;
        assign tick[k]    = tick_q;
        assign pending[k] = pend;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: table-driven vectors plus phase-formula sequences through a scoreboard queue.
module tb_clk_div_prog;
    localparam int N_CH  = 2;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en, load, clk_out, tick, pending;
    logic                  sync;
    logic [N_CH*CNT_W-1:0] div, high;

    always #5 clk = ~clk;

    clk_div_prog #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(128), .DEF_HIGH(64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .high(high),
        .load(load), .sync(sync), .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] t;
        logic [1:0] p;
    } exp_t;

    typedef struct {
        logic        en;
        logic        ld;
        logic        sy;
        logic [15:0] dv;
        logic [15:0] hi;
        logic        c;
        logic        t;
        logic        p;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[21];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input string name, input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        load = '0;
        sync = 1'b0;
        x = sb.pop_front();
        chk({name, ".clk_out"}, clk_out, x.c);
        chk({name, ".tick"}, tick, x.t);
        chk({name, ".pending"}, pending, x.p);
    endtask

    function automatic exp_t ph1(input int ph, input int hi, input logic pend);
        exp_t e;
        e.c = {1'b0, ph < hi};
        e.t = {1'b0, ph == 0};
        e.p = {1'b0, pend};
        return e;
    endfunction

    task automatic run_phase(input string name, input int n, input int per, input int hi,
                             input int start, input logic pend);
        for (int j = 0; j < n; j++) begin
            step(name, ph1((start + j) % per, hi, pend));
        end
    endtask

    task automatic load0(input logic [15:0] d, input logic [15:0] h, input logic s);
        div[15:0]  = d;
        high[15:0] = h;
        load       = 2'b01;
        sync       = s;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        en    = 2'b01;
        load  = '0;
        sync  = 1'b0;
        div   = '0;
        high  = '0;

        // Clamping, disable and re-enable vectors for channel 0
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'd1,  16'd5, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'd6,  16'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 16'd10, 16'd5, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'd4,  16'd2, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 1'b1, 1'b0};

        #2;
        chk("reset.clk_out", clk_out, 2'b00);
        chk("reset.tick", tick, 2'b00);
        chk("reset.pending", pending, 2'b00);
        #10 rst_n = 1'b1;

        // Defaults: 64 high / 64 low, tick every 128; stop at cnt=40
        run_phase("default", 297, 128, 64, 0, 1'b0);
        load0(16'd10, 16'd3, 1'b0);
        step("load_mid", ph1(41, 64, 1'b1));
        run_phase("pend_hold", 86, 128, 64, 42, 1'b1);
        run_phase("div10", 30, 10, 3, 0, 1'b0);

        // Load in wrap cycle stays pending for one extra period
        load0(16'd5, 16'd2, 1'b0);
        step("load_wrap", ph1(0, 3, 1'b1));
        run_phase("wrap_hold", 9, 10, 3, 1, 1'b1);
        run_phase("div5", 12, 5, 2, 0, 1'b0);

        // Load + sync together applies at once, pending never raised
        load0(16'd7, 16'd4, 1'b1);
        step("load_sync", ph1(0, 4, 1'b0));
        run_phase("div7", 13, 7, 4, 1, 1'b0);

        for (int i = 0; i < 21; i++) begin
            en         = {1'b0, tbl[i].en};
            load       = {1'b0, tbl[i].ld};
            sync       = tbl[i].sy;
            div[15:0]  = tbl[i].dv;
            high[15:0] = tbl[i].hi;
            e.c = {1'b0, tbl[i].c};
            e.t = {1'b0, tbl[i].t};
            e.p = {1'b0, tbl[i].p};
            step($sformatf("tbl%0d", i), e);
        end

        // Reset mid-period with a pending config: outputs drop at once, config discarded
        load0(16'd20, 16'd10, 1'b0);
        step("pre_rst", ph1(1, 2, 1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.clk_out", clk_out, 2'b00);
        chk("midrst.tick", tick, 2'b00);
        chk("midrst.pending", pending, 2'b00);
        #2 rst_n = 1'b1;
        en = 2'b00;
        step("rst_idle", ph1(1, 0, 1'b0));
        en = 2'b01;
        run_phase("after_rst", 130, 128, 64, 0, 1'b0);

        // Two channels aligned by sync; coincident ticks every 24 cycles
        en     = 2'b11;
        load   = 2'b11;
        sync   = 1'b1;
        div    = {16'd12, 16'd8};
        high   = {16'd6, 16'd4};
        for (int j = 0; j < 50; j++) begin
            e.c = {(j % 12) < 6, (j % 8) < 4};
            e.t = {(j % 12) == 0, (j % 8) == 0};
            e.p = 2'b00;
            step("two_ch", e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
